// File: rtl/ysyx_22050535_idu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ysyx_22050535_idu : RV32I decode/issue stage with scoreboard interlock |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module ysyx_22050535_idu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [4:0]            rs1_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_func3,
  output logic [6:0]            out_func7,
  output logic [4:0]            out_rd,
  output logic                  out_illegal,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic                  flush
);

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  logic [6:0]            w_opcode;
  logic [4:0]            w_rd;
  logic                  w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
  logic                  w_legal, w_uses_rs1, w_uses_rs2, w_writes_rd;
  logic [31:0]           w_imm32;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [31:0]           w_busy;
  logic                  w_hazard, w_accept;

  logic [31:1]           busy_d, busy_q;
  logic                  out_valid_q, out_illegal_q, out_wrote_q;
  logic [DATA_WIDTH-1:0] out_src1_q, out_src2_q, out_imm_q, out_pc_q;
  logic [6:0]            out_opcode_q, out_func7_q;
  logic [2:0]            out_func3_q;
  logic [4:0]            out_rd_q;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign w_is_r = (w_opcode == c_op_reg);
  assign w_is_i = (w_opcode == c_op_imm) || (w_opcode == c_op_load) || (w_opcode == c_op_jalr);
  assign w_is_s = (w_opcode == c_op_store);
  assign w_is_b = (w_opcode == c_op_branch);
  assign w_is_u = (w_opcode == c_op_lui) || (w_opcode == c_op_auipc);
  assign w_is_j = (w_opcode == c_op_jal);

  assign w_legal     = w_is_r | w_is_i | w_is_s | w_is_b | w_is_u | w_is_j;
  assign w_uses_rs1  = w_is_r | w_is_i | w_is_s | w_is_b;
  assign w_uses_rs2  = w_is_r | w_is_s | w_is_b;
  assign w_writes_rd = (w_is_r | w_is_i | w_is_u | w_is_j) && (w_rd != 5'd0);

  always_comb begin
    w_imm32 = 32'd0;
    if (w_is_i) begin
      w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    end else if (w_is_s) begin
      w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    end else if (w_is_b) begin
      w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    end else if (w_is_u) begin
      w_imm32 = {in_inst[31:12], 12'd0};
    end else if (w_is_j) begin
      w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    end
  end

  generate
    if (DATA_WIDTH > 32) begin : g_imm_sext
      assign w_imm = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_trunc
      assign w_imm = w_imm32[DATA_WIDTH-1:0];
    end
  endgenerate

  // x0 never becomes busy, so its scoreboard slot is a constant zero.
  assign w_busy   = {busy_q, 1'b0};
  assign w_hazard = (w_uses_rs1 & w_busy[rs1_addr]) | (w_uses_rs2 & w_busy[rs2_addr]);
  assign in_ready = (!out_valid_q || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid & in_ready;

  // Clears first, then the set from a new accept, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != 5'd0)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (flush && out_valid_q && out_wrote_q) begin
      busy_d[out_rd_q] = 1'b0;
    end
    if (w_accept && w_writes_rd) begin
      busy_d[w_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      out_wrote_q   <= 1'b0;
      out_src1_q    <= '0;
      out_src2_q    <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      out_opcode_q  <= '0;
      out_func3_q   <= '0;
      out_func7_q   <= '0;
      out_rd_q      <= '0;
    end else begin
      busy_q <= busy_d;
      if (w_accept) begin
        out_valid_q   <= 1'b1;
        out_illegal_q <= !w_legal;
        out_wrote_q   <= w_writes_rd;
        out_src1_q    <= w_uses_rs1 ? rs1_data : '0;
        out_src2_q    <= w_uses_rs2 ? rs2_data : '0;
        out_imm_q     <= w_imm;
        out_pc_q      <= in_pc;
        out_opcode_q  <= w_opcode;
        out_func3_q   <= in_inst[14:12];
        out_func7_q   <= in_inst[31:25];
        out_rd_q      <= w_rd;
      end else if (flush || out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_src1    = out_src1_q;
  assign out_src2    = out_src2_q;
  assign out_imm     = out_imm_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_opcode_q;
  assign out_func3   = out_func3_q;
  assign out_func7   = out_func7_q;
  assign out_rd      = out_rd_q;

endmodule
`default_nettype wire
